// File: rtl/posit_pkg.sv
// rtl/posit_pkg.sv - shared posit constants and decoded-field types
package posit_pkg;

    localparam int DEFAULT_BITS = 32;
    localparam int DEFAULT_ES   = 3;

    localparam logic [DEFAULT_BITS-1:0] POSIT_ZERO = '0;
    localparam logic [DEFAULT_BITS-1:0] POSIT_NAR  = {1'b1, {(DEFAULT_BITS-1){1'b0}}};

    typedef struct packed {
        logic                           sign;
        logic signed [DEFAULT_BITS-1:0] seed;
        logic [DEFAULT_ES-1:0]          exp;
        logic [DEFAULT_BITS-1:0]        frac;
        logic                           zero;
        logic                           nar;
    } posit_fields_t;

endpackage

// File: rtl/regime_counter.sv
// rtl/regime_counter.sv - run-length detector for the posit regime field
module regime_counter #(
    parameter int N  = 31,
    parameter int CW = 6
) (
    input  logic [N-1:0]  bits_i,
    output logic [CW-1:0] m_o,
    output logic          r_o
);

    localparam logic [CW-1:0] ONE = 1;

    logic run;

    // Count leading bits equal to the MSB; the first differing bit ends the run.
    always_comb begin
        r_o = bits_i[N-1];
        m_o = '0;
        run = 1'b1;
        for (int i = N - 1; i >= 0; i--) begin
            if (run && (bits_i[i] == r_o)) begin
                m_o = m_o + ONE;
            end else begin
                run = 1'b0;
            end
        end
    end

endmodule

// File: rtl/posit_unpacker.sv
// rtl/posit_unpacker.sv - two-stage posit field decoder; UNPACKER_NAR_EN enables NaR detection
module posit_unpacker
    import posit_pkg::*;
#(
    parameter int BITS = DEFAULT_BITS,
    parameter int ES   = DEFAULT_ES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [BITS-1:0]        in_posit,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   sign,
    output logic signed [BITS-1:0] seed,
    output logic [ES-1:0]          exp,
    output logic [BITS-1:0]        frac,
    output logic                   zero,
    output logic                   nar
);

    localparam int CW = $clog2(BITS) + 1;
    localparam logic [CW-1:0] ONE_CW = 1;
    localparam logic [BITS-1:0] ONE_B = 1;

    logic                   s1_valid_q, s1_sign_q, s1_zero_q, s1_nar_q;
    logic [BITS-2:0]        s1_mag_q;
    logic                   s1_sign_d, s1_zero_d, s1_nar_d;
    logic [BITS-2:0]        s1_mag_d;

    logic                   s2_valid_q, s2_sign_q, s2_zero_q, s2_nar_q;
    logic signed [BITS-1:0] s2_seed_q, s2_seed_d;
    logic [ES-1:0]          s2_exp_q, s2_exp_d;
    logic [BITS-1:0]        s2_frac_q, s2_frac_d;

    logic                   s2_ready, in_fire, s1_adv;
    logic [CW-1:0]          run_len, shamt;
    logic                   run_bit;
    logic [BITS-1:0]        run_ext;
    logic [BITS+ES-1:0]     tail;

    assign s2_ready = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_ready;
    assign in_fire  = in_valid && in_ready;
    assign s1_adv   = s1_valid_q && s2_ready;

    // Only the low BITS-1 bits of the magnitude ever feed the regime/exponent/fraction decode.
    assign s1_sign_d = in_posit[BITS-1];
    assign s1_mag_d  = s1_sign_d ? -in_posit[BITS-2:0] : in_posit[BITS-2:0];
    assign s1_zero_d = (in_posit == '0);
`ifdef UNPACKER_NAR_EN
    assign s1_nar_d  = (in_posit == {1'b1, {(BITS-1){1'b0}}});
`else
    assign s1_nar_d  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_mag_q   <= '0;
            s1_zero_q  <= 1'b0;
            s1_nar_q   <= 1'b0;
        end else begin
            if (in_fire) begin
                s1_valid_q <= 1'b1;
                s1_sign_q  <= s1_sign_d;
                s1_mag_q   <= s1_mag_d;
                s1_zero_q  <= s1_zero_d;
                s1_nar_q   <= s1_nar_d;
            end else if (s1_adv) begin
                s1_valid_q <= 1'b0;
            end
        end
    end

    regime_counter #(
        .N  (BITS - 1),
        .CW (CW)
    ) u_regime_counter (
        .bits_i (s1_mag_q),
        .m_o    (run_len),
        .r_o    (run_bit)
    );

    // Shift out the regime run plus its terminator; what remains is exponent then fraction.
    assign shamt   = run_len + ONE_CW;
    assign tail    = {s1_mag_q, {(ES+1){1'b0}}} << shamt;
    assign run_ext = {{(BITS-CW){1'b0}}, run_len};

    always_comb begin
        s2_seed_d = run_bit ? (run_ext - ONE_B) : -run_ext;
        s2_exp_d  = tail[BITS+ES-1 -: ES];
        s2_frac_d = tail[BITS-1:0];
        if (s1_zero_q || s1_nar_q) begin
            s2_seed_d = '0;
            s2_exp_d  = '0;
            s2_frac_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_seed_q  <= '0;
            s2_exp_q   <= '0;
            s2_frac_q  <= '0;
            s2_zero_q  <= 1'b0;
            s2_nar_q   <= 1'b0;
        end else if (s2_ready) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_sign_q <= s1_sign_q;
                s2_seed_q <= s2_seed_d;
                s2_exp_q  <= s2_exp_d;
                s2_frac_q <= s2_frac_d;
                s2_zero_q <= s1_zero_q;
                s2_nar_q  <= s1_nar_q;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign sign      = s2_valid_q & s2_sign_q;
    assign seed      = s2_valid_q ? s2_seed_q : '0;
    assign exp       = s2_valid_q ? s2_exp_q : '0;
    assign frac      = s2_valid_q ? s2_frac_q : '0;
    assign zero      = s2_valid_q & s2_zero_q;
    assign nar       = s2_valid_q & s2_nar_q;

endmodule

// File: tb/tb_posit_unpacker.sv
// tb/tb_posit_unpacker.sv - scoreboard bench for posit_unpacker; honours UNPACKER_NAR_EN
module tb_posit_unpacker;
    import posit_pkg::*;

    localparam int BITS = 32;
    localparam int ES   = 3;
    localparam int NVEC = 12;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid, in_ready, out_valid, out_ready;
    logic [BITS-1:0]        in_posit;
    logic                   sign, zero, nar;
    logic signed [BITS-1:0] seed;
    logic [ES-1:0]          exp;
    logic [BITS-1:0]        frac;

    always #5 clk = ~clk;

    posit_unpacker #(.BITS(BITS), .ES(ES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_posit  (in_posit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sign      (sign),
        .seed      (seed),
        .exp       (exp),
        .frac      (frac),
        .zero      (zero),
        .nar       (nar)
    );

    int            n_checks = 0;
    int            n_pass   = 0;
    int            cyc      = 0;
    bit            lat_chk  = 1'b0;
    posit_fields_t exp_q[$];
    int            acc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
    endtask

    function automatic posit_fields_t fld(input logic s, input int k, input logic [2:0] e,
                                          input logic [31:0] f, input logic z, input logic n);
        posit_fields_t r;
        r.sign = s; r.seed = k; r.exp = e; r.frac = f; r.zero = z; r.nar = n;
        return r;
    endfunction

    always @(negedge clk) begin
        posit_fields_t e;
        int            a;
        #2;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 1, 0);
            end else begin
                e = exp_q.pop_front();
                a = acc_q.pop_front();
                check("sign", sign, e.sign);
                check("seed", seed, e.seed);
                check("exp", exp, e.exp);
                check("frac", frac, e.frac);
                check("zero", zero, e.zero);
                check("nar", nar, e.nar);
                if (lat_chk) check("latency", cyc - a, 2);
            end
        end
    end

    task automatic send(input logic [31:0] p, input posit_fields_t e);
        int waited = 0;
        @(negedge clk);
        in_posit = p;
        in_valid = 1'b1;
        #1;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            check("send_timeout", 0, 1);
        end else begin
            exp_q.push_back(e);
            acc_q.push_back(cyc);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 60) begin
            @(negedge clk);
            w++;
        end
        check("drain", exp_q.size(), 0);
        #3;
        check("idle_valid", out_valid, 0);
        check("idle_seed", seed, 0);
        check("idle_frac", frac, 0);
        check("idle_sign", sign, 0);
    endtask

    logic [31:0]   pats[NVEC];
    posit_fields_t exps[NVEC];

    initial begin
        pats[0]  = 32'h4000_0000; exps[0]  = fld(0,   0, 3'd0, 32'h0,         0, 0);
        pats[1]  = 32'h4A00_0000; exps[1]  = fld(0,   0, 3'd2, 32'h8000_0000, 0, 0);
        pats[2]  = 32'hB600_0000; exps[2]  = fld(1,   0, 3'd2, 32'h8000_0000, 0, 0);
        pats[3]  = 32'h7FFF_FFFF; exps[3]  = fld(0,  30, 3'd0, 32'h0,         0, 0);
        pats[4]  = 32'h0000_0001; exps[4]  = fld(0, -30, 3'd0, 32'h0,         0, 0);
        pats[5]  = 32'h0000_0000; exps[5]  = fld(0,   0, 3'd0, 32'h0,         1, 0);
`ifdef UNPACKER_NAR_EN
        pats[6]  = 32'h8000_0000; exps[6]  = fld(1,   0, 3'd0, 32'h0,         0, 1);
`else
        pats[6]  = 32'h8000_0000; exps[6]  = fld(1, -31, 3'd0, 32'h0,         0, 0);
`endif
        pats[7]  = 32'h2000_0000; exps[7]  = fld(0,  -1, 3'd0, 32'h0,         0, 0);
        pats[8]  = 32'h6000_0000; exps[8]  = fld(0,   1, 3'd0, 32'h0,         0, 0);
        pats[9]  = 32'hFFFF_FFFF; exps[9]  = fld(1, -30, 3'd0, 32'h0,         0, 0);
        pats[10] = 32'h5B40_0000; exps[10] = fld(0,   0, 3'd6, 32'hD000_0000, 0, 0);
        pats[11] = 32'h0C00_0000; exps[11] = fld(0,  -3, 3'd4, 32'h0,         0, 0);

        rst = 1'b1; in_valid = 1'b0; in_posit = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_seed", seed, 0);
        check("rst_frac", frac, 0);
        check("rst_zero", zero, 0);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back decode of the vector table with a fixed two-cycle latency.
        lat_chk = 1'b1;
        for (int i = 0; i < NVEC; i++) send(pats[i], exps[i]);
        wait_drain();
        lat_chk = 1'b0;

        // Backpressure: two posits fill the pipe, the third must wait.
        @(negedge clk);
        out_ready = 1'b0;
        send(32'h4A00_0000, exps[1]);
        send(32'h6000_0000, exps[8]);
        @(negedge clk);
        in_posit = 32'h7FFF_FFFF;
        in_valid = 1'b1;
        #1;
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("stall_hold_frac", frac, 32'h8000_0000);
            check("stall_hold_exp", exp, 2);
            check("stall_hold_ready", in_ready, 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("release_in_ready", in_ready, 1);
        exp_q.push_back(exps[3]);
        acc_q.push_back(cyc);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_drain();

        // Reset with both stages full discards everything in flight.
        @(negedge clk);
        out_ready = 1'b0;
        send(32'h4A00_0000, exps[1]);
        send(32'h6000_0000, exps[8]);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_frac", frac, 0);
        exp_q.delete();
        acc_q.delete();
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        in_posit = 32'h5B40_0000;
        in_valid = 1'b1;
        #1;
        check("postrst_in_ready", in_ready, 1);
        exp_q.push_back(exps[10]);
        acc_q.push_back(cyc);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
